// File: rtl/lp_tree_deserializer.sv
// Receive side of the single-wire link: frames start/data/parity/stop bits back
// into WIDTH-bit words and flags parity and framing errors with one-cycle pulses.
module lp_tree_deserializer #(
  parameter int WIDTH     = 16,
  parameter bit PARITY_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             SERIAL_IN,
  output logic [WIDTH-1:0] PAR_OUT,
  output logic             VALID,
  output logic             PARITY_ERR,
  output logic             FRAME_ERR,
  output logic             BUSY
);

  // state  | meaning
  // IDLE   | waiting for a 1 (start bit) on SERIAL_IN
  // DATA   | shifting in WIDTH data bits, MSB first
  // PARITY | sampling the even-parity bit
  // STOP   | sampling the stop bit, issuing the result pulse
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             par_bad_q, par_bad_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shreg_q   <= '0;
      par_out_q <= '0;
      par_bad_q <= 1'b0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shreg_q   <= shreg_d;
      par_out_q <= par_out_d;
      par_bad_q <= par_bad_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    par_out_d = par_out_q;
    par_bad_d = par_bad_q;
    valid_d   = 1'b0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (SERIAL_IN) begin
          state_d   = DATA;
          cnt_d     = '0;
          par_bad_d = 1'b0;
        end
      end
      DATA: begin
        shreg_d = {shreg_q[WIDTH-2:0], SERIAL_IN};
        if (cnt_q == LAST) begin
          state_d = PARITY_EN ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PARITY: begin
        par_bad_d = ^{shreg_q, SERIAL_IN};
        state_d   = STOP;
      end
      STOP: begin
        // A high stop bit is a framing error and is never reused as a start.
        state_d = IDLE;
        ferr_d  = SERIAL_IN;
        perr_d  = par_bad_q;
        if (!SERIAL_IN && !par_bad_q) begin
          valid_d   = 1'b1;
          par_out_d = shreg_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign PAR_OUT    = par_out_q;
  assign VALID      = valid_q;
  assign PARITY_ERR = perr_q;
  assign FRAME_ERR  = ferr_q;
  assign BUSY       = (state_q != IDLE);

endmodule

// File: tb/tb_lp_tree_deserializer.sv
// Bench for lp_tree_deserializer: frames are scheduled as whole transactions and the
// expected per-cycle outputs come from frame contents and start-bit timing.
module tb_lp_tree_deserializer;

  localparam int W    = 16;
  localparam int MAXC = 8192;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          SERIAL_IN = 1'b0;
  logic [W-1:0]  PAR_OUT;
  logic          VALID, PARITY_ERR, FRAME_ERR, BUSY;

  lp_tree_deserializer #(.WIDTH(W), .PARITY_EN(1'b1)) dut (
    .CLK(CLK), .RESET(RESET), .SERIAL_IN(SERIAL_IN), .PAR_OUT(PAR_OUT),
    .VALID(VALID), .PARITY_ERR(PARITY_ERR), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  bit          exp_v  [MAXC];
  bit          exp_pe [MAXC];
  bit          exp_fe [MAXC];
  bit          exp_bz [MAXC];
  logic [W-1:0] exp_wd [MAXC];
  logic [W-1:0] m_par = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Per-cycle monitor: sampled 1 time unit after each rising edge.
  initial begin
    forever begin
      @(posedge CLK);
      cyc++;
      #1;
      if (cyc < MAXC) begin
        if (exp_v[cyc]) m_par = exp_wd[cyc];
        chk("valid", 32'(VALID), 32'(exp_v[cyc]));
        chk("parity_err", 32'(PARITY_ERR), 32'(exp_pe[cyc]));
        chk("frame_err", 32'(FRAME_ERR), 32'(exp_fe[cyc]));
        chk("busy", 32'(BUSY), 32'(exp_bz[cyc]));
        chk("par_out", 32'(PAR_OUT), 32'(m_par));
      end
    end
  end

  task automatic drive_bit(input logic b);
    @(negedge CLK);
    SERIAL_IN = b;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    SERIAL_IN = 1'b0;
    for (int c = cyc + 1; c < cyc + 40 && c < MAXC; c++) begin
      exp_v[c] = 0; exp_pe[c] = 0; exp_fe[c] = 0; exp_bz[c] = 0;
    end
    m_par = '0;
    #1;
    chk("rst_par_out", 32'(PAR_OUT), 32'h0);
    chk("rst_busy", 32'(BUSY), 32'h0);
    chk("rst_pulses", {29'd0, VALID, PARITY_ERR, FRAME_ERR}, 32'h0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  // abort_bits >= 0: reset the DUT after that many data bits have been sent.
  task automatic send_frame(input logic [W-1:0] data, input logic pbit, input logic stop,
                            input int gap, input int abort_bits = -1);
    int t;
    bit pok;
    drive_bit(1'b1);
    t = cyc + 1;
    pok = ((($countones(data) + int'(pbit)) % 2) == 0);
    if (t + W + 2 < MAXC) begin
      for (int c = t; c <= t + W + 1; c++) exp_bz[c] = 1;
      exp_v[t + W + 2]  = !stop && pok;
      exp_wd[t + W + 2] = data;
      exp_pe[t + W + 2] = !pok;
      exp_fe[t + W + 2] = stop;
    end
    for (int i = W - 1; i >= 0; i--) begin
      if (abort_bits >= 0 && (W - 1 - i) == abort_bits) begin
        do_reset();
        return;
      end
      drive_bit(data[i]);
    end
    drive_bit(pbit);
    drive_bit(stop);
    for (int g = 0; g < gap; g++) drive_bit(1'b0);
  endtask

  function automatic logic even_par(input logic [W-1:0] d);
    return ^d;
  endfunction

  initial begin
    logic [W-1:0] d;
    logic pb, sb;
    repeat (5) @(negedge CLK);
    chk("hold_par_out", 32'(PAR_OUT), 32'h0);
    chk("hold_flags", {28'd0, VALID, PARITY_ERR, FRAME_ERR, BUSY}, 32'h0);
    RESET = 1'b1;
    repeat (3) drive_bit(1'b0);

    send_frame(16'hC5AF, 1'b0, 1'b0, 2);
    send_frame(16'hFF00, 1'b0, 1'b0, 0);
    send_frame(16'h0001, 1'b1, 1'b0, 2);
    send_frame(16'h8811, 1'b1, 1'b0, 1);
    send_frame(16'hA815, 1'b0, 1'b1, 0);
    send_frame(16'hA995, 1'b0, 1'b0, 3);
    send_frame(16'hF00F, 1'b0, 1'b0, 0, 8);
    send_frame(16'hCC33, 1'b0, 1'b0, 2);

    for (int k = 0; k < 60; k++) begin
      d  = W'($urandom);
      pb = even_par(d) ^ ($urandom_range(0, 4) == 0);
      sb = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0)
        send_frame(d, pb, sb, $urandom_range(0, 3), $urandom_range(0, W - 1));
      else
        send_frame(d, pb, sb, $urandom_range(0, 3));
    end

    repeat (25) drive_bit(1'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
